lvds_rx_deframer: RTL and testbench

// - Upstream neighbour of the SMI controller: turns the modem's LVDS I/Q bitstream into framed 32-bit sample words.
// - Input is one bit-pair per i_sys_clk from the LVDS DDR input cells. Output is pushes into one RX FIFO (0.9 GHz or 2.4 GHz).
// - One instance per band. Each instance hunts sync, assembles words, checks framing, and reports overflow and framing errors.

---
 rtl/lvds_rx_pkg.sv | 40 ++++
 rtl/lvds_rx_deframer_sat_counter.sv | 26 ++
 rtl/lvds_rx_deframer.sv | 157 +++++++++++++++
 tb/tb_lvds_rx_deframer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_rx_pkg.sv
// Shared framing definitions for the LVDS RX deframer.
// The SMI side uses the same field positions to unpack I/Q.
package lvds_rx_pkg;

   localparam logic [1:0] DEF_SYNC_I = 2'b10;
   localparam logic [1:0] DEF_SYNC_Q = 2'b01;
   localparam int         DEF_ERR_W  = 8;

   localparam int WORD_W = 32;
   localparam int PAIRS  = 16;

   // Word bit-field positions
   localparam int SI_MSB = 31;
   localparam int SI_LSB = 30;
   localparam int I_MSB  = 29;
   localparam int I_LSB  = 16;
   localparam int SQ_MSB = 15;
   localparam int SQ_LSB = 14;
   localparam int Q_MSB  = 13;
   localparam int Q_LSB  = 0;

   // Pair index of SYNC_Q (the pair landing in [15:14]) and of the last pair
   localparam logic [3:0] CNT_SQ   = 4'd8;
   localparam logic [3:0] CNT_LAST = 4'd15;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      CAPTURE = 2'd1,
      EXPECT  = 2'd2
   } state_t;

   function automatic logic [13:0] word_i(input logic [WORD_W-1:0] w);
      return w[I_MSB:I_LSB];
   endfunction

   function automatic logic [13:0] word_q(input logic [WORD_W-1:0] w);
      return w[Q_MSB:Q_LSB];
   endfunction

endpackage

// File: rtl/lvds_rx_deframer_sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear has priority over a coincident increment.
module sat_counter
   import lvds_rx_pkg::*;
#(
   parameter int W = DEF_ERR_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   // Count up on inc, stick at all-ones, clear wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/lvds_rx_deframer.sv
// LVDS I/Q deframer: hunts sync, assembles 16-pair words,
// checks framing, pushes words to the RX FIFO.
module lvds_rx_deframer
   import lvds_rx_pkg::*;
#(
   parameter logic [1:0] SYNC_I = DEF_SYNC_I,
   parameter logic [1:0] SYNC_Q = DEF_SYNC_Q,
   parameter int         ERR_W  = DEF_ERR_W
) (
   input  logic              i_sys_clk,
   input  logic              i_rst_b,
   input  logic              i_enable,
   input  logic              i_clear_status,
   input  logic [1:0]        i_ddr_data,
   output logic              o_fifo_push,
   output logic [31:0]       o_fifo_data,
   input  logic              i_fifo_full,
   output logic              o_locked,
   output logic              o_overflow,
   output logic [ERR_W-1:0]  o_err_count
);

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  cnt;
   logic [3:0]  cnt_nxt;
   logic [31:0] sreg;
   logic [31:0] sreg_nxt;
   logic [4:0]  pos;
   logic        err_evt;
   logic        done;

   // Bit offset of the current pair: pair n lands at [31-2n:30-2n]
   assign pos = {4'd15 - cnt, 1'b0};

   // State register
   always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
      if (!i_rst_b) begin
         state <= HUNT;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, pair counter, shift register and framing events
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sreg_nxt  = sreg;
      err_evt   = 1'b0;
      done      = 1'b0;
      if (!i_enable) begin
         state_nxt = HUNT;
         cnt_nxt   = '0;
         sreg_nxt  = '0;
      end else begin
         unique case (state)
            HUNT: begin
               if (i_ddr_data == SYNC_I) begin
                  sreg_nxt                = '0;
                  sreg_nxt[SI_MSB:SI_LSB] = i_ddr_data;
                  cnt_nxt                 = 4'd1;
                  state_nxt               = CAPTURE;
               end
            end
            CAPTURE: begin
               sreg_nxt[pos +: 2] = i_ddr_data;
               cnt_nxt            = cnt + 4'd1;
               if ((cnt == CNT_SQ) && (i_ddr_data != SYNC_Q)) begin
                  err_evt   = 1'b1;
                  cnt_nxt   = '0;
                  sreg_nxt  = '0;
                  state_nxt = HUNT;
               end else if (cnt == CNT_LAST) begin
                  done      = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = EXPECT;
               end
            end
            EXPECT: begin
               if (i_ddr_data == SYNC_I) begin
                  sreg_nxt                = '0;
                  sreg_nxt[SI_MSB:SI_LSB] = i_ddr_data;
                  cnt_nxt                 = 4'd1;
                  state_nxt               = CAPTURE;
               end else begin
                  err_evt   = 1'b1;
                  state_nxt = HUNT;
               end
            end
            default: begin
               state_nxt = HUNT;
               cnt_nxt   = '0;
               sreg_nxt  = '0;
            end
         endcase
      end
   end

   // Pair counter and word shift register
   always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
      if (!i_rst_b) begin
         cnt  <= '0;
         sreg <= '0;
      end else begin
         cnt  <= cnt_nxt;
         sreg <= sreg_nxt;
      end
   end

   // FIFO push strobe and held output word
   always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
      if (!i_rst_b) begin
         o_fifo_push <= 1'b0;
         o_fifo_data <= '0;
      end else begin
         o_fifo_push <= 1'b0;
         if (done && !i_fifo_full) begin
            o_fifo_push <= 1'b1;
            o_fifo_data <= sreg_nxt;
         end
      end
   end

   // Lock flag: set on each completed word, dropped on error or disable
   always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
      if (!i_rst_b) begin
         o_locked <= 1'b0;
      end else if (!i_enable || err_evt) begin
         o_locked <= 1'b0;
      end else if (done) begin
         o_locked <= 1'b1;
      end
   end

   // Sticky overflow; a coincident clear wins
   always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
      if (!i_rst_b) begin
         o_overflow <= 1'b0;
      end else if (i_clear_status) begin
         o_overflow <= 1'b0;
      end else if (done && i_fifo_full) begin
         o_overflow <= 1'b1;
      end
   end

   sat_counter #(
      .W (ERR_W)
   ) u_err_cnt (
      .clk   (i_sys_clk),
      .rst_n (i_rst_b),
      .inc   (err_evt),
      .clr   (i_clear_status),
      .count (o_err_count)
   );

endmodule

// File: tb/tb_lvds_rx_deframer.sv
// Self-checking bench for lvds_rx_deframer: directed table,
// hand sequences, and a random stream against a scanning model.
module tb_lvds_rx_deframer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        clr = 1'b0;
   logic        full = 1'b0;
   logic [1:0]  ddr = 2'b00;
   logic        push;
   logic [31:0] data;
   logic        locked;
   logic        ovf;
   logic [7:0]  errc;

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   lvds_rx_deframer dut (
      .i_sys_clk      (clk),
      .i_rst_b        (rst_n),
      .i_enable       (en),
      .i_clear_status (clr),
      .i_ddr_data     (ddr),
      .o_fifo_push    (push),
      .o_fifo_data    (data),
      .i_fifo_full    (full),
      .o_locked       (locked),
      .o_overflow     (ovf),
      .o_err_count    (errc)
   );

   typedef struct {
      logic [31:0] word;
      logic        full;
      logic        push;
      logic [31:0] data;
      logic        locked;
      logic        ovf;
      logic [7:0]  err;
   } vec_t;

   vec_t tbl[7];

   logic [1:0]  pq[$];
   bit          fq[$];
   bit          e_push[$];
   logic [31:0] e_data[$];
   bit          e_lock[$];
   int          e_err[$];
   bit          e_ovf[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      else
         passed++;
   endtask

   task automatic step(input logic [1:0] p, input logic e,
                       input logic c, input logic f);
      @(negedge clk);
      ddr  = p;
      en   = e;
      clr  = c;
      full = f;
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] w, input logic f);
      for (int k = 0; k < 16; k++)
         step(w[31-2*k -: 2], 1'b1, 1'b0, f);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      en    = 1'b0;
      clr   = 1'b0;
      full  = 1'b0;
      ddr   = 2'b00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Scan the pair stream word by word; produce per-edge expectations
   task automatic run_model();
      int n;
      int i;
      int s;
      int ec;
      bit lk;
      bit ov;
      logic [31:0] w;
      logic [31:0] last;
      int lk_ev[];
      bit er_ev[];
      bit ov_ev[];
      bit ps_ev[];
      logic [31:0] wd[];
      n = pq.size();
      lk_ev = new[n];
      er_ev = new[n];
      ov_ev = new[n];
      ps_ev = new[n];
      wd = new[n];
      i = 0;
      while (i < n) begin
         if (pq[i] != 2'b10) begin
            i++;
            continue;
         end
         s = i;
         forever begin
            if (s + 8 >= n) begin i = n; break; end
            if (pq[s+8] != 2'b01) begin
               er_ev[s+8] = 1'b1;
               lk_ev[s+8] = 2;
               i = s + 9;
               break;
            end
            if (s + 15 >= n) begin i = n; break; end
            w = '0;
            for (int k = 0; k < 16; k++) w = {w[29:0], pq[s+k]};
            if (fq[s+15]) ov_ev[s+15] = 1'b1;
            else begin ps_ev[s+15] = 1'b1; wd[s+15] = w; end
            lk_ev[s+15] = 1;
            if (s + 16 >= n) begin i = n; break; end
            if (pq[s+16] == 2'b10) s = s + 16;
            else begin
               er_ev[s+16] = 1'b1;
               lk_ev[s+16] = 2;
               i = s + 17;
               break;
            end
         end
      end
      lk = 1'b0; ov = 1'b0; ec = 0; last = '0;
      for (int t = 0; t < n; t++) begin
         if (lk_ev[t] == 1) lk = 1'b1;
         if (lk_ev[t] == 2) lk = 1'b0;
         if (er_ev[t] && ec < 255) ec++;
         if (ov_ev[t]) ov = 1'b1;
         if (ps_ev[t]) last = wd[t];
         e_push.push_back(ps_ev[t]);
         e_data.push_back(last);
         e_lock.push_back(lk);
         e_err.push_back(ec);
         e_ovf.push_back(ov);
      end
   endtask

   initial begin
      logic [31:0] w;
      logic [1:0] bad;
      tbl[0] = '{32'h80004000, 1'b0, 1'b1, 32'h80004000, 1'b1, 1'b0, 8'd0};
      tbl[1] = '{32'h80004000, 1'b0, 1'b1, 32'h80004000, 1'b1, 1'b0, 8'd0};
      tbl[2] = '{32'h80004000, 1'b0, 1'b1, 32'h80004000, 1'b1, 1'b0, 8'd0};
      tbl[3] = '{32'h8000C000, 1'b0, 1'b0, 32'h80004000, 1'b0, 1'b0, 8'd1};
      tbl[4] = '{32'h9ABC5DEF, 1'b0, 1'b1, 32'h9ABC5DEF, 1'b1, 1'b0, 8'd1};
      tbl[5] = '{32'h80004000, 1'b1, 1'b0, 32'h9ABC5DEF, 1'b1, 1'b1, 8'd1};
      tbl[6] = '{32'h9ABC5DEF, 1'b0, 1'b1, 32'h9ABC5DEF, 1'b1, 1'b1, 8'd1};

      do_reset();
      #1;
      chk("rst_push", push, 0);
      chk("rst_data", data, 0);
      chk("rst_lock", locked, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_err", errc, 0);

      // Directed words, continuous stream
      for (int v = 0; v < 7; v++) begin
         send_word(tbl[v].word, tbl[v].full);
         chk($sformatf("tbl%0d_push", v), push, tbl[v].push);
         chk($sformatf("tbl%0d_data", v), data, tbl[v].data);
         chk($sformatf("tbl%0d_lock", v), locked, tbl[v].locked);
         chk($sformatf("tbl%0d_ovf", v), ovf, tbl[v].ovf);
         chk($sformatf("tbl%0d_err", v), errc, tbl[v].err);
      end

      // Disable at pair 10 for 4 cycles
      w = 32'h80004000;
      for (int k = 0; k < 16; k++) begin
         step(w[31-2*k -: 2], !(k >= 10 && k <= 13), 1'b0, 1'b0);
         if (k == 10) chk("dis_lock", locked, 0);
         if (k >= 10) chk("dis_push", push, 0);
      end
      chk("dis_ovf_hold", ovf, 1);
      chk("dis_err_hold", errc, 1);
      send_word(32'h9ABC5DEF, 1'b0);
      chk("reen_push", push, 1);
      chk("reen_data", data, 32'h9ABC5DEF);
      chk("reen_lock", locked, 1);

      // EXPECT error and status clear on the same edge
      step(2'b00, 1'b1, 1'b1, 1'b0);
      chk("clr_err", errc, 0);
      chk("clr_ovf", ovf, 0);
      chk("clr_lock", locked, 0);

      // Asynchronous reset mid-word
      w = 32'h80004000;
      for (int k = 0; k < 6; k++) step(w[31-2*k -: 2], 1'b1, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_data", data, 0);
      chk("arst_push", push, 0);
      chk("arst_lock", locked, 0);
      @(negedge clk);
      rst_n = 1'b1;
      send_word(32'h8ABC5DEF, 1'b0);
      chk("arst_next_push", push, 1);
      chk("arst_next_data", data, 32'h8ABC5DEF);

      // Saturation of the error counter
      for (int i = 0; i < 300; i++) begin
         send_word(32'h80004000, 1'b0);
         step(2'b00, 1'b1, 1'b0, 1'b0);
         chk($sformatf("sat%0d", i), errc, (i + 1 > 255) ? 255 : i + 1);
      end
      send_word(32'h80004000, 1'b0);
      chk("sat_hold", errc, 255);
      step(2'b11, 1'b1, 1'b1, 1'b0);
      chk("sat_clr", errc, 0);

      // Random stream against the scanning model
      do_reset();
      for (int j = 0; j < 5; j++) begin pq.push_back(2'b00); fq.push_back(1'b0); end
      for (int j = 0; j < 30; j++) begin
         if ($urandom_range(0, 4) == 0) begin
            for (int g = 0; g < $urandom_range(1, 3); g++) begin
               pq.push_back(2'($urandom_range(0, 3)));
               fq.push_back($urandom_range(0, 7) == 0);
            end
         end
         w = {2'b10, 14'($urandom), 2'b01, 14'($urandom)};
         if ($urandom_range(0, 5) == 0) begin
            bad = 2'($urandom_range(0, 2));
            if (bad == 2'b01) bad = 2'b11;
            w[15:14] = bad;
         end
         for (int k = 0; k < 16; k++) begin
            pq.push_back(w[31-2*k -: 2]);
            fq.push_back($urandom_range(0, 7) == 0);
         end
      end
      for (int j = 0; j < 20; j++) begin pq.push_back(2'b00); fq.push_back(1'b0); end
      run_model();
      for (int t = 0; t < pq.size(); t++) begin
         step(pq[t], 1'b1, 1'b0, fq[t]);
         chk($sformatf("rnd%0d_push", t), push, e_push[t]);
         chk($sformatf("rnd%0d_data", t), data, e_data[t]);
         chk($sformatf("rnd%0d_lock", t), locked, e_lock[t]);
         chk($sformatf("rnd%0d_err", t), errc, e_err[t]);
         chk($sformatf("rnd%0d_ovf", t), ovf, e_ovf[t]);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
